// File: rtl/nora_bus_pkg.sv
// Shared definitions for the NORA internal slave bus: field widths, command
// address slicing and the initiator state encoding.
package nora_bus_pkg;

    localparam int NORA_SLV_ADDR_W = 4;
    localparam int NORA_DEV_IDX_W  = 4;
    localparam int NORA_DATA_W     = 8;
    localparam int NORA_CMD_ADDR_W = NORA_DEV_IDX_W + NORA_SLV_ADDR_W;
    localparam int NORA_REG_LSB    = 0;
    localparam int NORA_IDX_LSB    = NORA_SLV_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPT,
        ST_RESP
    } nora_state_e;

    function automatic logic [NORA_DEV_IDX_W-1:0] nora_dev_idx(
        input logic [NORA_CMD_ADDR_W-1:0] addr
    );
        return addr[NORA_IDX_LSB +: NORA_DEV_IDX_W];
    endfunction

    function automatic logic [NORA_SLV_ADDR_W-1:0] nora_reg_addr(
        input logic [NORA_CMD_ADDR_W-1:0] addr
    );
        return addr[NORA_REG_LSB +: NORA_SLV_ADDR_W];
    endfunction

endpackage

// File: rtl/nora_slv_initiator_if.sv
// Command/response handshake plus slave-bus signals of the NORA initiator.
// 'master' is the initiator's view; 'slave' is the upstream agent plus devices.
interface nora_slv_initiator_if #(
    parameter int NUM_SLV = 4
) ();
    import nora_bus_pkg::*;

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic                          cmd_rwn;
    logic [NORA_CMD_ADDR_W-1:0]    cmd_addr;
    logic [NORA_DATA_W-1:0]        cmd_wdata;
    logic                          resp_valid;
    logic                          resp_ready;
    logic [NORA_DATA_W-1:0]        resp_rdata;
    logic                          resp_err;
    logic [NUM_SLV-1:0]            slv_req_o;
    logic [NORA_SLV_ADDR_W-1:0]    slv_addr_o;
    logic                          slv_rwn_o;
    logic [NORA_DATA_W-1:0]        slv_datawr_o;
    logic                          slv_datawr_valid_o;
    logic [NORA_DATA_W*NUM_SLV-1:0] slv_datard_i;

    modport master (
        input  cmd_valid, cmd_rwn, cmd_addr, cmd_wdata, resp_ready, slv_datard_i,
        output cmd_ready, resp_valid, resp_rdata, resp_err,
               slv_req_o, slv_addr_o, slv_rwn_o, slv_datawr_o, slv_datawr_valid_o
    );

    modport slave (
        output cmd_valid, cmd_rwn, cmd_addr, cmd_wdata, resp_ready, slv_datard_i,
        input  cmd_ready, resp_valid, resp_rdata, resp_err,
               slv_req_o, slv_addr_o, slv_rwn_o, slv_datawr_o, slv_datawr_valid_o
    );

endinterface

// File: rtl/nora_slv_decode.sv
// Device-index decode: one-hot request vector, unmapped flag and read-data mux.
module nora_slv_decode
    import nora_bus_pkg::*;
#(
    parameter int NUM_SLV = 4
) (
    input  logic [NORA_DEV_IDX_W-1:0]      idx_i,
    input  logic [NORA_DATA_W*NUM_SLV-1:0] datard_i,
    output logic [NUM_SLV-1:0]             onehot_o,
    output logic                           miss_o,
    output logic [NORA_DATA_W-1:0]         rdata_o
);

    always_comb begin
        onehot_o = '0;
        rdata_o  = '0;
        miss_o   = (int'(idx_i) >= NUM_SLV);
        for (int k = 0; k < NUM_SLV; k++) begin
            if (int'(idx_i) == k) begin
                onehot_o[k] = 1'b1;
                rdata_o     = datard_i[NORA_DATA_W*k +: NORA_DATA_W];
            end
        end
    end

endmodule

// File: rtl/nora_slv_initiator.sv
// Initiator end of the NORA slave bus: turns one upstream command into a
// REQ_CYCLES-long slave access and returns exactly one response per command.
module nora_slv_initiator
    import nora_bus_pkg::*;
#(
    parameter int                     NUM_SLV      = 4,
    parameter int                     REQ_CYCLES   = 3,
    parameter logic [NORA_DATA_W-1:0] RD_MISS_DATA = 8'hFF
) (
    input logic                  clk6x,
    input logic                  reset,
    nora_slv_initiator_if.master bus
);

    localparam int               CNT_W    = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    nora_state_e                 state_q,       state_d;
    logic [CNT_W-1:0]            cnt_q,         cnt_d;
    logic [NORA_DEV_IDX_W-1:0]   idx_q,         idx_d;
    logic [NUM_SLV-1:0]          req_q,         req_d;
    logic [NORA_SLV_ADDR_W-1:0]  slv_addr_q,    slv_addr_d;
    logic                        slv_rwn_q,     slv_rwn_d;
    logic [NORA_DATA_W-1:0]      slv_wdata_q,   slv_wdata_d;
    logic                        dwv_q,         dwv_d;
    logic                        cmd_ready_q,   cmd_ready_d;
    logic                        resp_valid_q,  resp_valid_d;
    logic [NORA_DATA_W-1:0]      resp_rdata_q,  resp_rdata_d;
    logic                        resp_err_q,    resp_err_d;

    logic [NORA_DEV_IDX_W-1:0]   dec_idx;
    logic [NUM_SLV-1:0]          dec_onehot;
    logic                        dec_miss;
    logic [NORA_DATA_W-1:0]      dec_rdata;
    logic                        accept;

    // One decoder serves both the incoming command (IDLE) and the capture (CAPT).
    assign dec_idx = (state_q == ST_IDLE) ? nora_dev_idx(bus.cmd_addr) : idx_q;
    assign accept  = bus.cmd_valid && cmd_ready_q;

    nora_slv_decode #(.NUM_SLV(NUM_SLV)) u_decode (
        .idx_i    (dec_idx),
        .datard_i (bus.slv_datard_i),
        .onehot_o (dec_onehot),
        .miss_o   (dec_miss),
        .rdata_o  (dec_rdata)
    );

    always_comb begin
        // NOTE: every next-state value gets a default first, so no branch can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        req_d        = req_q;
        slv_addr_d   = slv_addr_q;
        slv_rwn_d    = slv_rwn_q;
        slv_wdata_d  = slv_wdata_q;
        dwv_d        = 1'b0;
        cmd_ready_d  = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    idx_d       = nora_dev_idx(bus.cmd_addr);
                    cnt_d       = CNT_LOAD;
                    if (dec_miss) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = bus.cmd_rwn ? RD_MISS_DATA : '0;
                    end else begin
                        state_d     = ST_REQ;
                        req_d       = dec_onehot;
                        slv_addr_d  = nora_reg_addr(bus.cmd_addr);
                        slv_rwn_d   = bus.cmd_rwn;
                        slv_wdata_d = bus.cmd_wdata;
                        resp_err_d  = 1'b0;
                        dwv_d       = !bus.cmd_rwn && (CNT_LOAD == '0);
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q == '0) begin
                    req_d = '0;
                    if (slv_rwn_q) begin
                        state_d = ST_CAPT;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    // Strobe is registered, so raise it when entering the final REQ cycle.
                    dwv_d = !slv_rwn_q && (cnt_q == CNT_ONE);
                end
            end
            ST_CAPT: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = dec_rdata;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk6x or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            req_q        <= '0;
            slv_addr_q   <= '0;
            slv_rwn_q    <= 1'b1;
            slv_wdata_q  <= '0;
            dwv_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            req_q        <= req_d;
            slv_addr_q   <= slv_addr_d;
            slv_rwn_q    <= slv_rwn_d;
            slv_wdata_q  <= slv_wdata_d;
            dwv_q        <= dwv_d;
            cmd_ready_q  <= cmd_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.cmd_ready          = cmd_ready_q;
    assign bus.resp_valid         = resp_valid_q;
    assign bus.resp_rdata         = resp_rdata_q;
    assign bus.resp_err           = resp_err_q;
    assign bus.slv_req_o          = req_q;
    assign bus.slv_addr_o         = slv_addr_q;
    assign bus.slv_rwn_o          = slv_rwn_q;
    assign bus.slv_datawr_o       = slv_wdata_q;
    assign bus.slv_datawr_valid_o = dwv_q;

endmodule

// File: tb/tb_nora_slv_initiator.sv
// Directed bench for nora_slv_initiator: a REQ_CYCLES=3 instance (a) and a
// REQ_CYCLES=1 instance (b), each with four registered slave models.
module tb_nora_slv_initiator;

    logic clk6x = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk6x = ~clk6x;

    nora_slv_initiator_if #(.NUM_SLV(4)) bus_a ();
    nora_slv_initiator_if #(.NUM_SLV(4)) bus_b ();

    nora_slv_initiator #(.NUM_SLV(4), .REQ_CYCLES(3), .RD_MISS_DATA(8'hFF)) dut_a (
        .clk6x (clk6x),
        .reset (reset),
        .bus   (bus_a)
    );

    nora_slv_initiator #(.NUM_SLV(4), .REQ_CYCLES(1), .RD_MISS_DATA(8'hFF)) dut_b (
        .clk6x (clk6x),
        .reset (reset),
        .bus   (bus_b)
    );

    // Slave k register r reads back {k, r} ^ 8'h5D, registered while requested.
    function automatic logic [7:0] slv_val(input int k, input logic [3:0] a);
        logic [3:0] kk;
        kk = k[3:0];
        return {kk, a} ^ 8'h5D;
    endfunction

    logic [7:0] rd_a [4];
    logic [7:0] rd_b [4];

    always @(posedge clk6x) begin
        for (int k = 0; k < 4; k++) begin
            if (bus_a.slv_req_o[k] === 1'b1) rd_a[k] <= slv_val(k, bus_a.slv_addr_o);
            if (bus_b.slv_req_o[k] === 1'b1) rd_b[k] <= slv_val(k, bus_b.slv_addr_o);
        end
    end

    assign bus_a.slv_datard_i = {rd_a[3], rd_a[2], rd_a[1], rd_a[0]};
    assign bus_b.slv_datard_i = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};

    // Write observer on bus a.
    int         wr_cnt_a = 0;
    logic [3:0] wr_req_a;
    logic [3:0] wr_addr_a;
    logic [7:0] wr_data_a;

    always @(posedge clk6x) begin
        if (bus_a.slv_datawr_valid_o === 1'b1) begin
            wr_cnt_a  <= wr_cnt_a + 1;
            wr_req_a  <= bus_a.slv_req_o;
            wr_addr_a <= bus_a.slv_addr_o;
            wr_data_a <= bus_a.slv_datawr_o;
        end
    end

    // Bus-rule observer: one-hot request, strobe only on a requested write.
    int viol = 0;

    always @(negedge clk6x) begin
        if ($countones(bus_a.slv_req_o) > 1 ||
            (bus_a.slv_datawr_valid_o === 1'b1 && (bus_a.slv_rwn_o !== 1'b0 || bus_a.slv_req_o == 4'b0)))
            viol <= viol + 1;
        else if ($countones(bus_b.slv_req_o) > 1 ||
            (bus_b.slv_datawr_valid_o === 1'b1 && (bus_b.slv_rwn_o !== 1'b0 || bus_b.slv_req_o == 4'b0)))
            viol <= viol + 1;
    end

    logic [3:0] h_req   [16];
    logic       h_dwv   [16];
    logic       h_rv    [16];
    logic [3:0] h_addr  [16];
    logic       h_rwn   [16];
    logic [7:0] h_dw    [16];
    logic [7:0] h_rdata [16];
    logic       h_err   [16];

    task automatic record_a(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk6x);
            h_req[c]   = bus_a.slv_req_o;
            h_dwv[c]   = bus_a.slv_datawr_valid_o;
            h_rv[c]    = bus_a.resp_valid;
            h_addr[c]  = bus_a.slv_addr_o;
            h_rwn[c]   = bus_a.slv_rwn_o;
            h_dw[c]    = bus_a.slv_datawr_o;
            h_rdata[c] = bus_a.resp_rdata;
            h_err[c]   = bus_a.resp_err;
        end
    endtask

    // Offers one command on bus a; returns #1 after the accepting edge (cycle 0).
    task automatic issue_a(input logic rwn, input logic [7:0] addr, input logic [7:0] wdata,
                           output bit tmo);
        int n;
        n = 0;
        @(negedge clk6x);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_rwn   = rwn;
        bus_a.cmd_addr  = addr;
        bus_a.cmd_wdata = wdata;
        while (bus_a.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk6x);
            n++;
        end
        tmo = (bus_a.cmd_ready !== 1'b1);
        @(posedge clk6x);
        #1;
        bus_a.cmd_valid = 1'b0;
    endtask

    task automatic take_resp_a();
        @(negedge clk6x);
        bus_a.resp_ready = 1'b1;
        @(posedge clk6x);
        #1;
        bus_a.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] got_a, got_b, exp_v;
        reset = 1'b1;
        repeat (3) @(negedge clk6x);
        exp_v = {1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0};
        got_a = {bus_a.cmd_ready, bus_a.resp_valid, bus_a.resp_err, bus_a.resp_rdata,
                 bus_a.slv_req_o, bus_a.slv_addr_o, bus_a.slv_rwn_o, bus_a.slv_datawr_o,
                 bus_a.slv_datawr_valid_o};
        got_b = {bus_b.cmd_ready, bus_b.resp_valid, bus_b.resp_err, bus_b.resp_rdata,
                 bus_b.slv_req_o, bus_b.slv_addr_o, bus_b.slv_rwn_o, bus_b.slv_datawr_o,
                 bus_b.slv_datawr_valid_o};
        checks++;
        if (got_a !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs_a got=%h exp=%h", got_a, exp_v);
        end
        checks++;
        if (got_b !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs_b got=%h exp=%h", got_b, exp_v);
        end
        reset = 1'b0;
        @(negedge clk6x);
        checks++;
        if (bus_a.cmd_ready !== 1'b1 || bus_b.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got_a=%b got_b=%b exp=1", bus_a.cmd_ready, bus_b.cmd_ready);
        end
    endtask

    task automatic test_write();
        bit         tmo;
        int         wr0;
        logic [5:0] got_v, exp_v;
        wr0 = wr_cnt_a;
        issue_a(1'b0, 8'h12, 8'hA5, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL write_accept got=timeout exp=accepted");
        end
        record_a(5);
        for (int c = 1; c <= 5; c++) begin
            got_v = {h_req[c], h_dwv[c], h_rv[c]};
            exp_v = {(c <= 3) ? 4'b0010 : 4'b0000, c == 3, c >= 4};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL write_cycle%0d req/dwv/rv got=%b exp=%b", c, got_v, exp_v);
            end
        end
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (h_addr[c] !== 4'h2 || h_rwn[c] !== 1'b0 || h_dw[c] !== 8'hA5) begin
                errors++;
                $display("FAIL write_bus_cycle%0d addr/rwn/data got=%h/%b/%h exp=2/0/a5",
                         c, h_addr[c], h_rwn[c], h_dw[c]);
            end
        end
        checks++;
        if (h_err[4] !== 1'b0 || h_rdata[4] !== 8'h00) begin
            errors++;
            $display("FAIL write_resp err/rdata got=%b/%h exp=0/00", h_err[4], h_rdata[4]);
        end
        checks++;
        if (wr_cnt_a !== wr0 + 1 || wr_req_a !== 4'b0010 || wr_addr_a !== 4'h2 || wr_data_a !== 8'hA5) begin
            errors++;
            $display("FAIL write_strobe cnt/req/addr/data got=%0d/%b/%h/%h exp=%0d/0010/2/a5",
                     wr_cnt_a - wr0, wr_req_a, wr_addr_a, wr_data_a, 1);
        end
        take_resp_a();
        @(negedge clk6x);
        checks++;
        if (bus_a.resp_valid !== 1'b0 || bus_a.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_done rv/ready got=%b/%b exp=0/1", bus_a.resp_valid, bus_a.cmd_ready);
        end
    endtask

    task automatic test_read();
        bit         tmo;
        logic [5:0] got_v, exp_v;
        issue_a(1'b1, 8'h01, 8'h00, tmo);
        checks++;
        if (tmo) begin
            errors++;
            $display("FAIL read_accept got=timeout exp=accepted");
        end
        record_a(6);
        for (int c = 1; c <= 6; c++) begin
            got_v = {h_req[c], h_dwv[c], h_rv[c]};
            exp_v = {(c <= 3) ? 4'b0001 : 4'b0000, 1'b0, c >= 5};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL read_cycle%0d req/dwv/rv got=%b exp=%b", c, got_v, exp_v);
            end
        end
        checks++;
        if (h_addr[2] !== 4'h1 || h_rwn[2] !== 1'b1) begin
            errors++;
            $display("FAIL read_bus addr/rwn got=%h/%b exp=1/1", h_addr[2], h_rwn[2]);
        end
        checks++;
        if (h_rdata[5] !== 8'h5C || h_err[5] !== 1'b0) begin
            errors++;
            $display("FAIL read_resp rdata/err got=%h/%b exp=5c/0", h_rdata[5], h_err[5]);
        end
        take_resp_a();
    endtask

    task automatic test_unmapped();
        logic       rwn_t   [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] addr_t  [3] = '{8'h71, 8'h43, 8'hF0};
        logic [7:0] rdata_t [3] = '{8'hFF, 8'hFF, 8'h00};
        bit         tmo;
        int         wr0;
        logic       bad;
        wr0 = wr_cnt_a;
        for (int i = 0; i < 3; i++) begin
            issue_a(rwn_t[i], addr_t[i], 8'h99, tmo);
            record_a(4);
            bad = tmo;
            for (int c = 1; c <= 4; c++)
                if (h_req[c] !== 4'b0 || h_rv[c] !== 1'b1) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL unmapped%0d_timing req1/rv1 got=%b/%b exp=0000/1", i, h_req[1], h_rv[1]);
            end
            checks++;
            if (h_err[1] !== 1'b1 || h_rdata[1] !== rdata_t[i]) begin
                errors++;
                $display("FAIL unmapped%0d_resp err/rdata got=%b/%h exp=1/%h", i, h_err[1], h_rdata[1], rdata_t[i]);
            end
            take_resp_a();
        end
        checks++;
        if (wr_cnt_a !== wr0 || bus_a.slv_addr_o !== 4'h1) begin
            errors++;
            $display("FAIL unmapped_no_access strobes/addr got=%0d/%h exp=0/1", wr_cnt_a - wr0, bus_a.slv_addr_o);
        end
    endtask

    task automatic test_backpressure();
        int   n;
        logic ready_seen, bad;
        n = 0;
        @(negedge clk6x);
        bus_a.cmd_valid = 1'b1;
        bus_a.cmd_rwn   = 1'b1;
        bus_a.cmd_addr  = 8'h23;
        bus_a.cmd_wdata = 8'h00;
        while (bus_a.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk6x);
            n++;
        end
        @(posedge clk6x);
        #1;
        bus_a.cmd_rwn   = 1'b0;
        bus_a.cmd_addr  = 8'h30;
        bus_a.cmd_wdata = 8'h11;
        ready_seen = 1'b0;
        bad        = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk6x);
            if (bus_a.cmd_ready !== 1'b0) ready_seen = 1'b1;
            if (c >= 4 && bus_a.slv_req_o !== 4'b0) bad = 1'b1;
            if (c >= 5 && (bus_a.resp_valid !== 1'b1 || bus_a.resp_rdata !== 8'h7E || bus_a.resp_err !== 1'b0))
                bad = 1'b1;
        end
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_busy got=%b exp=0", ready_seen);
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL bp_resp_stable rv/rdata got=%b/%h exp=1/7e", bus_a.resp_valid, bus_a.resp_rdata);
        end
        take_resp_a();
        @(negedge clk6x);
        checks++;
        if (bus_a.cmd_ready !== 1'b1 || bus_a.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_handshake ready/rv got=%b/%b exp=1/0", bus_a.cmd_ready, bus_a.resp_valid);
        end
        @(posedge clk6x);
        #1;
        bus_a.cmd_valid = 1'b0;
        record_a(5);
        checks++;
        if (h_req[1] !== 4'b1000 || h_req[3] !== 4'b1000 || h_dwv[3] !== 1'b1 || h_dw[3] !== 8'h11 ||
            h_addr[3] !== 4'h0 || h_rv[4] !== 1'b1) begin
            errors++;
            $display("FAIL bp_second_cmd req1/req3/dwv3/data3/rv4 got=%b/%b/%b/%h/%b exp=1000/1000/1/11/1",
                     h_req[1], h_req[3], h_dwv[3], h_dw[3], h_rv[4]);
        end
        take_resp_a();
    endtask

    task automatic test_reset_mid_req();
        bit   tmo;
        int   wr0, c;
        logic rv_seen;
        wr0 = wr_cnt_a;
        issue_a(1'b0, 8'h25, 8'h3C, tmo);
        @(posedge clk6x);
        #2;
        checks++;
        if (bus_a.slv_req_o !== 4'b0100) begin
            errors++;
            $display("FAIL midreq_active req got=%b exp=0100", bus_a.slv_req_o);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus_a.slv_req_o !== 4'b0 || bus_a.cmd_ready !== 1'b0 || bus_a.slv_rwn_o !== 1'b1) begin
            errors++;
            $display("FAIL midreq_async req/ready/rwn got=%b/%b/%b exp=0000/0/1",
                     bus_a.slv_req_o, bus_a.cmd_ready, bus_a.slv_rwn_o);
        end
        repeat (2) @(negedge clk6x);
        reset   = 1'b0;
        rv_seen = 1'b0;
        repeat (8) begin
            @(negedge clk6x);
            if (bus_a.resp_valid !== 1'b0) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen !== 1'b0 || wr_cnt_a !== wr0) begin
            errors++;
            $display("FAIL midreq_aborted rv_seen/strobes got=%b/%0d exp=0/0", rv_seen, wr_cnt_a - wr0);
        end
        issue_a(1'b1, 8'h02, 8'h00, tmo);
        c = 0;
        while (bus_a.resp_valid !== 1'b1 && c < 20) begin
            @(negedge clk6x);
            c++;
        end
        checks++;
        if (c !== 5 || bus_a.resp_rdata !== 8'h5F) begin
            errors++;
            $display("FAIL midreq_next latency/rdata got=%0d/%h exp=5/5f", c, bus_a.resp_rdata);
        end
        take_resp_a();
    endtask

    task automatic test_req1();
        int         n;
        logic [3:0] q_req [9];
        logic       q_rv  [9];
        logic [7:0] q_rd  [9];
        logic [4:0] got_v, exp_v;
        n = 0;
        @(negedge clk6x);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_rwn   = 1'b0;
        bus_b.cmd_addr  = 8'h1A;
        bus_b.cmd_wdata = 8'h5A;
        while (bus_b.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk6x);
            n++;
        end
        @(posedge clk6x);
        #1;
        bus_b.cmd_valid = 1'b0;
        @(negedge clk6x);
        checks++;
        if (bus_b.slv_req_o !== 4'b0010 || bus_b.slv_datawr_valid_o !== 1'b1 || bus_b.resp_valid !== 1'b0 ||
            bus_b.slv_addr_o !== 4'hA || bus_b.slv_datawr_o !== 8'h5A) begin
            errors++;
            $display("FAIL req1_write_c1 req/dwv/rv/addr/data got=%b/%b/%b/%h/%h exp=0010/1/0/a/5a",
                     bus_b.slv_req_o, bus_b.slv_datawr_valid_o, bus_b.resp_valid,
                     bus_b.slv_addr_o, bus_b.slv_datawr_o);
        end
        @(negedge clk6x);
        checks++;
        if (bus_b.slv_req_o !== 4'b0 || bus_b.slv_datawr_valid_o !== 1'b0 || bus_b.resp_valid !== 1'b1 ||
            bus_b.resp_err !== 1'b0 || bus_b.resp_rdata !== 8'h00) begin
            errors++;
            $display("FAIL req1_write_c2 req/dwv/rv/err/rdata got=%b/%b/%b/%b/%h exp=0000/0/1/0/00",
                     bus_b.slv_req_o, bus_b.slv_datawr_valid_o, bus_b.resp_valid,
                     bus_b.resp_err, bus_b.resp_rdata);
        end
        @(negedge clk6x);
        bus_b.resp_ready = 1'b1;
        @(posedge clk6x);
        #1;
        n = 0;
        @(negedge clk6x);
        bus_b.cmd_valid = 1'b1;
        bus_b.cmd_rwn   = 1'b1;
        bus_b.cmd_addr  = 8'h03;
        while (bus_b.cmd_ready !== 1'b1 && n < 40) begin
            @(negedge clk6x);
            n++;
        end
        @(posedge clk6x);
        #1;
        bus_b.cmd_addr = 8'h31;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk6x);
            q_req[c] = bus_b.slv_req_o;
            q_rv[c]  = bus_b.resp_valid;
            q_rd[c]  = bus_b.resp_rdata;
            if (c == 5) bus_b.cmd_valid = 1'b0;
        end
        bus_b.resp_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            got_v = {q_req[c], q_rv[c]};
            exp_v = {(c == 1) ? 4'b0001 : (c == 5) ? 4'b1000 : 4'b0000, c == 3 || c == 7};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL req1_b2b_cycle%0d req/rv got=%b exp=%b", c, got_v, exp_v);
            end
        end
        checks++;
        if (q_rd[3] !== 8'h5E || q_rd[7] !== 8'h6C) begin
            errors++;
            $display("FAIL req1_b2b_rdata got=%h/%h exp=5e/6c", q_rd[3], q_rd[7]);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL bus_rules violations got=%0d exp=0", viol);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus_a.cmd_valid  = 1'b0;
        bus_a.cmd_rwn    = 1'b1;
        bus_a.cmd_addr   = 8'h00;
        bus_a.cmd_wdata  = 8'h00;
        bus_a.resp_ready = 1'b0;
        bus_b.cmd_valid  = 1'b0;
        bus_b.cmd_rwn    = 1'b1;
        bus_b.cmd_addr   = 8'h00;
        bus_b.cmd_wdata  = 8'h00;
        bus_b.resp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_backpressure();
        test_reset_mid_req();
        test_req1();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
